reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_rport.sv | 31 +++
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Datapath package: register file geometry defaults and architectural
// register indices shared by the decoder, the muxes and the register file.
package reg_file_pkg;

    // Default geometry: 32 registers of 32 bits.
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    // Architectural register indices.
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage : reg_file_pkg

// File: rtl/reg_file_rport.sv
// One combinational read port of the register file. Selects the addressed
// entry, optionally forwards the in-flight write data, and forces register 0
// to read as zero regardless of the array contents or forwarding.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [ADDR_W-1:0] ra,
    input  logic              byp_valid,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] rd
);

    // Array lookup, then write-first forwarding, then the zero-register mask last
    // so that address 0 always wins.
    always_comb begin
        rd = regs[ra];
        if (byp_valid && (byp_addr == ra)) begin
            rd = byp_data;
        end
        if (ra == ADDR_W'(REG_ZERO)) begin
            rd = '0;
        end
    end

endmodule : reg_file_rport

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 2^ADDR_W x DATA_W, two combinational
// read ports, one synchronous write port, register 0 hard-wired to zero,
// asynchronous active-high clear of the whole array.
// Optional feature macro: REG_FILE_BYPASS_EN -- when defined, each read port
// forwards the write data combinationally when it addresses the register
// being written (write-first). When undefined, reads see the array only.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              byp_valid;

    // Next array state: a qualified write to a non-zero address updates one
    // entry; entry 0 is pinned to zero so it can never hold a stray value.
    // An unknown we fails the if-test and leaves the array untouched.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != ADDR_W'(REG_ZERO))) begin
            regs_d[wa] = wd;
        end
        regs_d[REG_ZERO] = '0;
    end

    // Array storage with asynchronous clear; clear wins over a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forward only a write that will really land: enabled, out of reset, non-zero.
    assign byp_valid = we && !rst && (wa != ADDR_W'(REG_ZERO));
`else
    // Read-before-write: ports reflect the array contents only.
    assign byp_valid = 1'b0;
`endif

    // Two identical read ports (rs and rt).
    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rport1 (
        .regs      (regs_q),
        .ra        (ra1),
        .byp_valid (byp_valid),
        .byp_addr  (wa),
        .byp_data  (wd),
        .rd        (rd1)
    );

    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rport2 (
        .regs      (regs_q),
        .ra        (ra2),
        .byp_valid (byp_valid),
        .byp_addr  (wa),
        .byp_data  (wd),
        .rd        (rd2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: an array model updated by the rules of the
// register file, a per-cycle compare of both read ports, and directed vectors
// with literal expected values.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa, ra1, ra2;
    logic [DW-1:0] wd, rd1, rd2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [DW-1:0] model [N];

    always #5 clk = ~clk;

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd),
        .ra1 (ra1), .ra2 (ra2), .rd1 (rd1), .rd2 (rd2)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: cleared while reset is high, otherwise a clean write to a
    // non-zero address stores the data.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) model[i] = '0;
        end else if (we === 1'b1 && wa != 0) begin
            model[wa] = wd;
        end
    end

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (rst === 1'b0 && we === 1'b1 && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rd1", rd1, expect_rd(ra1));
            check("cmp_rd2", rd2, expect_rd(ra2));
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #2;
        we = 1'b1; wa = a; wd = d;
        @(posedge clk); #2;
        we = 1'b0;
        $display("WR r%0d <= %h", a, d);
    endtask

    logic [AW-1:0] tbl_a [5];
    logic [DW-1:0] tbl_d [5];
    logic [DW-1:0] same_exp;

    initial begin
        tbl_a[0] = 5'd29; tbl_d[0] = 32'h7FFF_EFFC;
        tbl_a[1] = 5'd31; tbl_d[1] = 32'h0040_0010;
        tbl_a[2] = 5'd1;  tbl_d[2] = 32'h0000_0001;
        tbl_a[3] = 5'd2;  tbl_d[3] = 32'h8000_0000;
        tbl_a[4] = 5'd16; tbl_d[4] = 32'hA5A5_A5A5;

        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset sweep: every address reads zero.
        for (int i = 0; i < N; i++) begin
            ra1 = AW'(i); ra2 = AW'(N - 1 - i);
            #1;
            check("reset_rd1", rd1, 32'h0);
            check("reset_rd2", rd2, 32'h0);
        end
        $display("RD reset sweep done");

        // Basic write/read on both ports.
        wr(5'd8, 32'hDEAD_BEEF);
        ra1 = 5'd8; ra2 = 5'd8; #1;
        check("wr8_rd1", rd1, 32'hDEAD_BEEF);
        check("wr8_rd2", rd2, 32'hDEAD_BEEF);

        // Write to register 0 is discarded.
        wr(5'd0, 32'hFFFF_FFFF);
        ra1 = 5'd0; #1;
        check("zero_rd1", rd1, 32'h0);

        // Unknown we with wa=0 must not disturb the array.
        @(posedge clk); #2;
        we = 1'bx; wa = 5'd0; wd = 32'h1357_9BDF;
        @(posedge clk); #2;
        we = 1'b0;
        ra1 = 5'd8; ra2 = 5'd0; #1;
        check("xwe_rd1", rd1, 32'hDEAD_BEEF);
        check("xwe_rd2", rd2, 32'h0);
        $display("WR we=x wa=0 ignored");

        // Same-address read during write.
        wr(5'd9, 32'h1);
        we = 1'b1; wa = 5'd9; wd = 32'h2; ra1 = 5'd9; ra2 = 5'd8;
        #1;
`ifdef REG_FILE_BYPASS_EN
        same_exp = 32'h2;
`else
        same_exp = 32'h1;
`endif
        check("same_pre_rd1", rd1, same_exp);
        check("same_pre_rd2", rd2, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("same_post_rd1", rd1, 32'h2);
        #1 we = 1'b0;
        $display("WR r9 <= 00000002 (same-address read)");

        // we gating: no write with we=0.
        we = 1'b0; wa = 5'd10; wd = 32'h55AA_55AA; ra1 = 5'd10;
        @(posedge clk); #2;
        check("wegate_rd1", rd1, 32'h0);
        $display("WR we=0 r10 not written");

        // Table of writes, then read back in pairs.
        for (int i = 0; i < 5; i++) wr(tbl_a[i], tbl_d[i]);
        for (int i = 0; i < 5; i++) begin
            ra1 = tbl_a[i]; ra2 = tbl_a[4 - i]; #1;
            check("tbl_rd1", rd1, tbl_d[i]);
            check("tbl_rd2", rd2, tbl_d[4 - i]);
        end

        // Async reset between edges clears immediately.
        wr(5'd31, 32'h1234_5678);
        ra1 = 5'd31; ra2 = 5'd8; #1;
        check("pre_arst_rd1", rd1, 32'h1234_5678);
        #1 rst = 1'b1;
        #1;
        check("arst_rd1", rd1, 32'h0);
        check("arst_rd2", rd2, 32'h0);
        $display("RST async mid-cycle");
        @(posedge clk); #2 rst = 1'b0;

        // Write on the edge coincident with reset assertion is lost.
        wr(5'd31, 32'h1234_5678);
        we = 1'b1; wa = 5'd5; wd = 32'hCAFE_F00D; ra1 = 5'd5; ra2 = 5'd31;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("coinc_rd1", rd1, 32'h0);
        check("coinc_rd2", rd2, 32'h0);
        #1 we = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("coinc_after_rd1", rd1, 32'h0);
        $display("RST coincident with write r5");

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
